// File: rtl/pipelined_addsub.sv
// Registered add/sub with Carry/Ovf/Zero flags, a STAGES-deep valid/ready pipeline and a
// saturating overflow event counter. Define PIPELINED_ADDSUB_SATURATE_EN to clamp overflowing results.
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Result,
  output logic             Carry,
  output logic             Ovf,
  output logic             Zero,
  input  logic             ClrCount,
  output logic [CNT_W-1:0] OvfCount
);

  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] r;
    logic             c;
    logic             o;
    logic             z;
  } stage_t;

  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   sum;
  stage_t           nxt;
  stage_t           pipe [STAGES];
  logic             adv;

  always_comb begin
    bx      = Sub ? ~B : B;
    sum     = {1'b0, A} + {1'b0, bx} + {{WIDTH{1'b0}}, Sub};
    nxt.vld = InValid;
    nxt.c   = sum[WIDTH];
    nxt.o   = (A[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
    nxt.r   = sum[WIDTH-1:0];
`ifdef PIPELINED_ADDSUB_SATURATE_EN
    // Clamp towards the sign of A; Ovf/Carry keep reporting the raw condition.
    if (nxt.o)
      nxt.r = A[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
    nxt.z   = (nxt.r == '0);
  end

  // One global stall: the whole pipe moves only when the last stage is empty or being drained.
  assign adv     = ~pipe[STAGES-1].vld | OutReady;
  assign InReady = adv;

  // NOTE: every stage register (data included) is reset so no stale beat or value survives Rst_n.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < STAGES; i++) pipe[i] <= '0;
    end else if (adv) begin
      pipe[0] <= nxt;
      for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign OutValid = pipe[STAGES-1].vld;
  assign Result   = pipe[STAGES-1].r;
  assign Carry    = pipe[STAGES-1].c;
  assign Ovf      = pipe[STAGES-1].o;
  assign Zero     = pipe[STAGES-1].z;

  // Clear wins over a coincident counted handshake; the count sticks at all-ones.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      OvfCount <= '0;
    end else if (ClrCount) begin
      OvfCount <= '0;
    end else if (OutValid && OutReady && Ovf && (OvfCount != '1)) begin
      OvfCount <= OvfCount + CNT_W'(1);
    end
  end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised successor to the combinational 32-bit Adder.
- Adds or subtracts two WIDTH-bit operands and returns Carry/Overflow/Zero flags.
- Result passes through a STAGES-deep register pipeline under a valid/ready handshake, with a saturating overflow event counter.
- Used in the datapath/ALU wherever a registered, back-pressurable add/sub is needed.

Parameters:
- WIDTH, 32, operand and result width in bits (>=2)
- STAGES, 2, pipeline register depth = latency in cycles (1..4)
- CNT_W, 16, width of the overflow event counter

Ports:
- Clk  in  1  rising-edge clock
- Rst_n  in  1  asynchronous, active-low reset
- InValid  in  1  operand beat valid
- InReady  out  1  block can accept a beat this cycle
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- Sub  in  1  0: A+B, 1: A-B
- OutValid  out  1  result beat valid
- OutReady  in  1  downstream accepts result
- Result  out  WIDTH  sum/difference
- Carry  out  1  carry out of MSB (for Sub=1: 1 means no borrow)
- Ovf  out  1  signed two's-complement overflow
- Zero  out  1  Result == 0
- ClrCount  in  1  synchronous clear of OvfCount
- OvfCount  out  CNT_W  number of accepted beats with Ovf=1, saturating

Behaviour:
- Reset is asynchronous on Rst_n low. All stage valid bits, Result, Carry, Ovf, Zero and OvfCount go to 0.
- InReady is combinational with no registered dependency beyond stage valids; it is 1 during reset release.
- Arithmetic is computed combinationally at input:
  - Bx = Sub ? ~B : B
  - {Carry, R} = A + Bx + Sub, in WIDTH+1 bits
  - Ovf = (A[MSB] == Bx[MSB]) && (R[MSB] != A[MSB])
  - Zero = (R == 0)
- The pipeline is STAGES registers; each holds {valid, R, Carry, Ovf, Zero}.
- The stall is global: adv = ~valid[STAGES-1] | OutReady.
  - All stages shift when adv=1 and hold otherwise.
  - InReady = adv.
- A beat is accepted when InValid & InReady and is written to stage 0 with valid=1. If adv=1 and InValid=0, stage 0 loads valid=0 (a bubble).
- Latency: a beat accepted at edge N is presented on OutValid/Result after edge N+STAGES-1 when unstalled. With STAGES=1, the output registers directly.
- Outputs Result/Carry/Ovf/Zero come from the last stage. They are stable while OutValid=1 and OutReady=0.
- Throughput is 1 beat/cycle with OutReady held at 1. Bubbles are not compressed.
- Handshake rules:
  - OutValid must not drop without OutReady.
  - InValid with InReady=0 is ignored; the upstream must hold it.
- OvfCount increments on each output handshake (OutValid & OutReady) whose Ovf=1. It saturates at 2^CNT_W-1 and does not wrap.
- ClrCount has priority: if a clear and a counted handshake coincide, the count becomes 0.
- Reset mid-operation discards all in-flight beats. No partial outputs are produced.
- Edge cases:
  - Min-negative minus min-negative gives 0, Ovf=0.
  - Min-negative minus 1 gives Ovf=1.
  - Max-positive plus 1 gives Ovf=1.

Optional Feature:
- Macro: PIPELINED_ADDSUB_SATURATE_EN.
- When defined, a stage-0 write with Ovf=1 clamps R:
  - to 0x7F..F if A[MSB]=0
  - to 0x80..0 if A[MSB]=1
- Ovf and Carry still report the raw (unclamped) condition. Zero reflects the clamped R.
- When undefined, R wraps modulo 2^WIDTH and no clamp logic exists.

Test Plan (WIDTH=32, STAGES=2, OutReady=1 unless stated):
- 10+15, 1 beat -> after 2 cycles OutValid=1, Result=25, Carry=0, Ovf=0, Zero=0.
- A=-10 (0xFFFFFFF6), B=15 -> Result=5, Carry=1, Ovf=0. Then A=20, B=15, Sub=1 -> Result=5, Carry=1. Then A=7, B=7, Sub=1 -> Zero=1.
- 0x7FFFFFFF+1 -> Ovf=1, OvfCount 0->1.
  - Without the macro: Result=0x80000000.
  - With PIPELINED_ADDSUB_SATURATE_EN: Result=0x7FFFFFFF.
  - 0x80000000-1 with saturation -> 0x80000000, Ovf=1.
- Back-to-back 4 beats (1+1, 2+2, 3+3, 4+4) with OutReady low for 3 cycles after the first OutValid -> InReady=0 while stalled, Result held at 2. After release, outputs are 2, 4, 6, 8 in order with no loss or duplication.
- Rst_n pulsed low between clock edges with 2 beats in flight -> OutValid, Result, OvfCount read 0 immediately. No stale beat emerges after release.
- OvfCount preloaded to 0xFFFF via forced overflows (or CNT_W=2 build) -> further overflows leave it at max. ClrCount coinciding with an overflow handshake -> 0.
